// File: rtl/uart_word_streamer.sv
// uart_word_streamer: FIFO-buffered word transmitter sending each word as LSB-first UART byte frames
module uart_word_streamer #(
  parameter int DATA_LENGTH    = 16,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int CLKS_PER_BIT   = 16,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [DATA_LENGTH-1:0]  i_data,
  output logic                    o_ready,
  output logic                    o_tx,
  output logic                    o_tx_done,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic [FIFO_DEPTH_LOG:0] o_level
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int PW    = FIFO_DEPTH_LOG;
  localparam int LW    = FIFO_DEPTH_LOG + 1;
  localparam int NB    = DATA_LENGTH / 8;
  localparam int BW    = NB > 1 ? $clog2(NB) : 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] PAR   = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;
  logic [DATA_LENGTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ready_q, ready_d, overflow_q, overflow_d;
  logic                   push, pop;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [BW-1:0]          byte_q, byte_d;
  logic [DATA_LENGTH-1:0] shift_q, shift_d;
  logic                   par_q, par_d, tx_q, tx_d, done_q, done_d;
  logic                   line, bit_end, par_bit;
  assign line    = state_q == START || state_q == DATA || state_q == PAR || state_q == STOP;
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign pop     = state_q == LOAD;
  assign par_bit = PARITY == 2 ? ~par_q : par_q;
  // FIFO bookkeeping; ready is the registered not-full flag, so a push while full is dropped even on a pop cycle
  always_comb begin
    push       = i_valid && ready_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    ready_d    = level_d != LW'(DEPTH);
    overflow_d = overflow_q | (i_valid & ~ready_q);
  end
  // Word storage; contents need no reset because level gates every read
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end
  // Transmit FSM: bytes of a word go back to back, one LOAD cycle separates words
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    cnt_d   = (line && !bit_end) ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: state_d = level_q != '0 ? LOAD : IDLE;
      LOAD: begin
        shift_d = mem[rd_ptr_q];
        byte_d  = '0;
        bit_d   = '0;
        par_d   = 1'b0;
        state_d = START;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        par_d   = par_q ^ shift_q[0];
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: state_d = bit_end ? STOP : PAR;
      STOP: if (bit_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          bit_d  = '0;
          par_d  = 1'b0;
          if (byte_q != BW'(NB - 1)) begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end else begin
            state_d = level_q != '0 ? LOAD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Line value is registered from the current state so the output never glitches
  always_comb begin
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PAR ? par_bit : 1'b1;
  end
  // State registers; async reset forces the line idle at once and drops any partial frame
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end
  assign o_ready    = ready_q;
  assign o_tx       = tx_q;
  assign o_tx_done  = done_q;
  assign o_busy     = state_q != IDLE;
  assign o_overflow = overflow_q;
  assign o_level    = level_q;
endmodule

// File: tb/tb_uart_word_streamer.sv
// tb_uart_word_streamer: directed checks on four parameter variants sharing one clock
module tb_uart_word_streamer;
  localparam int CPB = 4;
  typedef struct packed {
    logic [1:0]  k;
    logic        stop_ok;
    logic        p;
    logic [7:0]  b;
    logic [31:0] t;
  } rec_t;
  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] t;
  } dn_t;
  logic        clk;
  logic [3:0]  rst_n, valid, ready, tx, done, busy, ovf;
  logic [15:0] data [4];
  logic [3:0]  level [4];
  logic [31:0] cyc;
  rec_t        rxq[$];
  dn_t         dq[$];
  int          n_cmp, n_bad;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Instances: 0 none/1 stop, 1 none/2 stop, 2 even/1 stop, 3 odd/1 stop
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int PE = g >= 2 ? 1 : 0;
    localparam int NS = g == 1 ? 2 : 1;
    uart_word_streamer #(
      .DATA_LENGTH(16), .FIFO_DEPTH_LOG(3), .CLKS_PER_BIT(CPB),
      .PARITY(g == 2 ? 1 : g == 3 ? 2 : 0), .STOP_BITS(NS)
    ) u_dut (
      .i_clock(clk), .i_reset(rst_n[g]), .i_valid(valid[g]), .i_data(data[g]),
      .o_ready(ready[g]), .o_tx(tx[g]), .o_tx_done(done[g]), .o_busy(busy[g]),
      .o_overflow(ovf[g]), .o_level(level[g])
    );
    initial begin : mon
      rec_t r;
      forever begin
        @(negedge clk);
        if (rst_n[g] && tx[g] == 1'b0) begin
          r = '0;
          r.k = 2'(g);
          r.t = cyc;
          r.stop_ok = 1'b1;
          repeat (CPB / 2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            r.b[i] = tx[g];
          end
          if (PE != 0) begin
            repeat (CPB) @(negedge clk);
            r.p = tx[g];
          end
          for (int s = 0; s < NS; s++) begin
            repeat (CPB) @(negedge clk);
            if (tx[g] != 1'b1) r.stop_ok = 1'b0;
          end
          rxq.push_back(r);
        end
      end
    end
    always @(negedge clk) if (done[g]) dq.push_back({2'(g), cyc});
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic get_rec(output rec_t r);
    int c = 0;
    while (rxq.size() == 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("rx_avail", 32'(rxq.size() != 0), 1);
    r = rxq.size() != 0 ? rxq.pop_front() : '0;
  endtask
  task automatic exp_byte(input string tag, input int k, input logic [7:0] b, output rec_t r);
    get_rec(r);
    check(tag, {r.k, r.stop_ok, r.b}, {k[1:0], 1'b1, b});
  endtask
  task automatic push(input int k, input logic [15:0] d);
    @(negedge clk);
    valid[k] = 1'b1;
    data[k] = d;
    @(negedge clk);
    valid[k] = 1'b0;
  endtask
  function automatic logic [15:0] wv(input int i);
    return {4'(i + 1), 8'h00, 4'(i + 1)};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rec_t r0, r1, r2, r3;
    n_cmp = 0;
    n_bad = 0;
    rst_n = '0;
    valid = '0;
    for (int k = 0; k < 4; k++) data[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_outs", {tx[k], ready[k], done[k], busy[k], ovf[k]}, 5'b11000);
      check("rst_level", level[k], 0);
    end
    rst_n = '1;
    repeat (2) @(negedge clk);
    // Start-up latency and single word 0xA53C
    dq.delete();
    push(0, 16'hA53C);
    check("lat_n", {level[0], busy[0], tx[0]}, {4'd1, 1'b0, 1'b1});
    @(negedge clk);
    check("lat_n1", {level[0], busy[0], tx[0]}, {4'd1, 1'b1, 1'b1});
    @(negedge clk);
    check("lat_n2", {level[0], busy[0], tx[0]}, {4'd0, 1'b1, 1'b1});
    @(negedge clk);
    check("lat_n3_tx", tx[0], 0);
    exp_byte("w1_b0", 0, 8'h3C, r0);
    exp_byte("w1_b1", 0, 8'hA5, r1);
    check("w1_frame", r1.t - r0.t, 40);
    repeat (4) @(negedge clk);
    check("w1_done_cnt", dq.size(), 2);
    if (dq.size() == 2) begin
      check("w1_done0_pos", dq[0].t - r0.t, 39);
      check("w1_done_gap", dq[1].t - dq[0].t, 40);
    end
    check("w1_idle", {busy[0], tx[0], level[0]}, {1'b0, 1'b1, 4'd0});
    // Even and odd parity on 0x0107
    push(2, 16'h0107);
    get_rec(r0);
    get_rec(r1);
    check("even_b0", {r0.k, r0.b, r0.p, r0.stop_ok}, {2'd2, 8'h07, 1'b1, 1'b1});
    check("even_b1", {r1.k, r1.b, r1.p, r1.stop_ok}, {2'd2, 8'h01, 1'b1, 1'b1});
    check("even_frame", r1.t - r0.t, 44);
    push(3, 16'h0107);
    get_rec(r0);
    get_rec(r1);
    check("odd_b0", {r0.k, r0.b, r0.p, r0.stop_ok}, {2'd3, 8'h07, 1'b0, 1'b1});
    check("odd_b1", {r1.k, r1.b, r1.p, r1.stop_ok}, {2'd3, 8'h01, 1'b0, 1'b1});
    check("odd_frame", r1.t - r0.t, 44);
    // Two stop bits, back-to-back words
    @(negedge clk);
    valid[1] = 1'b1;
    data[1] = 16'h1111;
    @(negedge clk);
    data[1] = 16'h2222;
    @(negedge clk);
    valid[1] = 1'b0;
    exp_byte("s2_b0", 1, 8'h11, r0);
    exp_byte("s2_b1", 1, 8'h11, r1);
    exp_byte("s2_b2", 1, 8'h22, r2);
    exp_byte("s2_b3", 1, 8'h22, r3);
    check("s2_gap_byte", r1.t - r0.t, 44);
    check("s2_gap_word", r2.t - r1.t, 45);
    check("s2_gap_byte2", r3.t - r2.t, 44);
    // Fill FIFO while the first word is on the line; ninth push overflows
    push(0, 16'hF00D);
    repeat (2) @(negedge clk);
    check("ov_pre", {level[0], busy[0], ovf[0]}, {4'd0, 1'b1, 1'b0});
    for (int i = 0; i < 9; i++) begin
      valid[0] = 1'b1;
      data[0] = wv(i);
      @(negedge clk);
      if (i == 7) check("ov_full", {level[0], ready[0], ovf[0]}, {4'd8, 1'b0, 1'b0});
    end
    valid[0] = 1'b0;
    check("ov_flag", {level[0], ready[0], ovf[0]}, {4'd8, 1'b0, 1'b1});
    exp_byte("ov_w0_lo", 0, 8'h0D, r0);
    exp_byte("ov_w0_hi", 0, 8'hF0, r0);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      w = wv(i);
      exp_byte("ov_lo", 0, w[7:0], r0);
      exp_byte("ov_hi", 0, w[15:8], r0);
    end
    repeat (100) @(negedge clk);
    check("ov_no_ninth", rxq.size(), 0);
    check("ov_end", {level[0], ready[0], ovf[0], busy[0]}, {4'd0, 1'b1, 1'b1, 1'b0});
    // Push exactly on the LOAD edge with three words stored
    push(0, 16'hA1B2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      valid[0] = 1'b1;
      data[0] = i == 0 ? 16'hC3D4 : i == 1 ? 16'hE5F6 : 16'h0718;
      @(negedge clk);
    end
    valid[0] = 1'b0;
    repeat (77) @(negedge clk);
    check("pp_before", level[0], 3);
    valid[0] = 1'b1;
    data[0] = 16'h293A;
    @(negedge clk);
    valid[0] = 1'b0;
    check("pp_after", level[0], 3);
    exp_byte("pp_a0", 0, 8'hB2, r0);
    exp_byte("pp_a1", 0, 8'hA1, r1);
    exp_byte("pp_b0", 0, 8'hD4, r2);
    check("pp_word_gap", r2.t - r1.t, 41);
    exp_byte("pp_b1", 0, 8'hC3, r0);
    exp_byte("pp_c0", 0, 8'hF6, r0);
    exp_byte("pp_c1", 0, 8'hE5, r0);
    exp_byte("pp_d0", 0, 8'h18, r0);
    exp_byte("pp_d1", 0, 8'h07, r0);
    exp_byte("pp_e0", 0, 8'h3A, r0);
    exp_byte("pp_e1", 0, 8'h29, r0);
    repeat (10) @(negedge clk);
    // Asynchronous reset during a data bit
    dq.delete();
    @(negedge clk);
    valid[0] = 1'b1;
    data[0] = 16'h0000;
    @(negedge clk);
    data[0] = 16'h1234;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("ar_pre", {tx[0], busy[0], level[0], ovf[0]}, {1'b0, 1'b1, 4'd1, 1'b1});
    #1 rst_n[0] = 1'b0;
    #1 check("ar_now", {tx[0], busy[0], level[0], ovf[0], ready[0], done[0]}, {1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (60) @(negedge clk);
    check("ar_no_done", dq.size(), 0);
    check("ar_idle", {tx[0], busy[0], level[0]}, {1'b1, 1'b0, 4'd0});
    rxq.delete();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
